crc16_check: RTL and testbench
==============================

# crc16_check

Receive-side USB CRC16 checker, the counterpart of the transmit CRC16 generator. It accepts a serial, MSB-first stream of DATA_BITS payload bits followed by the 16 transmitted (complemented) CRC bits. It runs the same x^16+x^15+x^2+1 LFSR, preset to all ones, over all DATA_BITS+16 bits. It then reports pass/fail against the fixed USB residual 16'h800D. It sits between the receive bit-unstuffer and the packet-level receive FSM.

## Interface
- DATA_BITS, 64, payload length in bits, excluding CRC; legal range 1..1000
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- crc_start  input  1  one-cycle pulse: begin a new packet check
- s_in  input  1  received serial bit, sampled only when bit_en=1
- bit_en  input  1  qualifies s_in; may have arbitrary gaps
- pkt_abort  input  1  upstream error or early EOP; terminates the current check
- crc_rec  input  1  consumer acknowledge of the result
- crc_busy  output  1  high while bits are being accepted
- crc_done  output  1  result valid; held until crc_rec
- crc_ok  output  1  residual matched and length correct; valid while crc_done
- crc_err  output  1  inverse of crc_ok while crc_done, else 0
- len_err  output  1  packet terminated by pkt_abort; valid while crc_done
- crc_rem  output  16  live LFSR contents, for debug and bench

## Operation
- LFSR next state when shifting (r = current, fb = r[15]^s_in):
  - r'[0] = fb
  - r'[1] = r[0]
  - r'[2] = r[1]^fb
  - r'[14:3] = r[13:2]
  - r'[15] = r[14]^fb
- LFSR preset value 16'hFFFF.
- Bit counter: width $clog2(DATA_BITS+17), clears to 0, terminal value TOTAL = DATA_BITS+16.
- FSM states and transitions:
  - IDLE: crc_start -> RECV. Preset the LFSR and clear the counter at that edge. bit_en is ignored.
  - RECV: crc_busy=1. Each bit_en cycle shifts the LFSR and increments the counter.
    - The bit that brings the count to TOTAL -> DONE. The result is registered at that same edge: crc_ok = (next LFSR == 16'h800D).
    - pkt_abort -> DONE with crc_ok=0, len_err=1. The LFSR is frozen and the abort-cycle bit is not shifted.
    - crc_start -> re-preset, clear the counter, stay in RECV. This restarts the check.
  - DONE: crc_done=1 and the outputs are stable. bit_en, pkt_abort and crc_start are ignored. crc_rec -> IDLE, clearing crc_done, crc_ok, crc_err and len_err.
- Simultaneous-event priority:
  - In RECV, pkt_abort beats the final bit and beats crc_start.
  - crc_start beats bit_en.
  - In DONE, crc_rec returns the block to IDLE; a crc_start in the same cycle is dropped.
- The counter never wraps. The final bit always transitions to DONE, so the count cannot exceed TOTAL.

## Timing
- Reset values:
  - state IDLE
  - crc_rem 16'hFFFF
  - counter 0
  - crc_busy, crc_done, crc_ok, crc_err, len_err all 0
- Reset asserted mid-RECV or mid-DONE: the result is discarded and all outputs return to reset values immediately (asynchronously).
- crc_start in cycle N -> crc_busy=1 from cycle N+1. The first bit is accepted in cycle N+1 at the earliest.
- Last bit accepted in cycle M -> crc_done=1 with a valid crc_ok, crc_err and len_err in cycle M+1. crc_busy=0 in cycle M+1.
- pkt_abort in cycle M -> crc_done=1, crc_err=1 and len_err=1 in cycle M+1.
- crc_rec in cycle K (while in DONE) -> crc_done=0 in cycle K+1. A new crc_start is accepted from cycle K+1.
- crc_rem updates one cycle after each accepted bit. It is unchanged on cycles with bit_en=0.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Good packet: DATA_BITS=64, payload 64'h0123_4567_89AB_CDEF followed by the 16 CRC bits produced by the team's crc16 generator for the same payload, with bit_en continuous -> crc_done one cycle after bit 80, crc_ok=1, crc_err=0, len_err=0, crc_rem=16'h800D.
- Corrupted packet: same stream with payload bit 17 inverted -> crc_done, crc_ok=0, crc_err=1, len_err=0, crc_rem!=16'h800D.
- Gapped stream: good packet with bit_en low on a random ~50% of cycles -> same result as the first scenario; crc_rem unchanged on every gap cycle.
- Abort and simultaneity:
  - pkt_abort after 10 bits -> crc_done, crc_err=1, len_err=1, crc_rem frozen at its 10-bit value.
  - pkt_abort coincident with bit 80 -> len_err=1.
- Restart and ack:
  - crc_start reasserted after 30 bits, then a full good packet -> crc_ok=1.
  - crc_rec together with crc_start in DONE -> IDLE; the second start is ignored and crc_busy stays 0.
- Reset mid-packet: rst_n low after 40 bits -> all outputs 0 and crc_rem=16'hFFFF immediately; after reset releases, a good packet passes with crc_ok=1.

Source files
------------

// File: rtl/crc16_check_if.sv
// crc16_check_if
// Bundles the packet-check handshake between the bit unstuffer / packet FSM
// (master) and the CRC16 receive checker (slave).
//   crc_start, s_in, bit_en, pkt_abort, crc_rec : master -> checker
//   crc_busy, crc_done, crc_ok, crc_err, len_err : checker -> master
//   crc_rem[15:0]                                : live LFSR contents
interface crc16_check_if;
  logic        crc_start;
  logic        s_in;
  logic        bit_en;
  logic        pkt_abort;
  logic        crc_rec;
  logic        crc_busy;
  logic        crc_done;
  logic        crc_ok;
  logic        crc_err;
  logic        len_err;
  logic [15:0] crc_rem;

  modport master (
    output crc_start, s_in, bit_en, pkt_abort, crc_rec,
    input  crc_busy, crc_done, crc_ok, crc_err, len_err, crc_rem
  );

  modport slave (
    input  crc_start, s_in, bit_en, pkt_abort, crc_rec,
    output crc_busy, crc_done, crc_ok, crc_err, len_err, crc_rem
  );
endinterface

// File: rtl/crc16_check.sv
// crc16_check
// Receive-side USB CRC16 checker. Shifts DATA_BITS payload bits plus the 16
// complemented CRC bits (serial, MSB first) through an x^16+x^15+x^2+1 LFSR
// preset to all ones, then compares the residual against 16'h800D.
// Ports:
//   i_clk    system clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      crc16_check_if.slave (start/bit/abort/ack in, status/residual out)
//
// state | meaning
// IDLE  | waiting for crc_start, bit_en ignored
// RECV  | accepting bits, crc_busy high
// DONE  | result held until crc_rec
module crc16_check #(
  parameter int DATA_BITS = 64
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  crc16_check_if.slave  bus
);

  localparam int          TOTAL    = DATA_BITS + 16;
  localparam int          CW       = $clog2(DATA_BITS + 17);
  localparam logic [15:0] PRESET   = 16'hFFFF;
  localparam logic [15:0] RESIDUAL = 16'h800D;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [15:0]     r_lfsr;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_done;
  logic            r_ok;
  logic            r_err;
  logic            r_len_err;

  logic            w_fb;
  logic [15:0]     w_lfsr_next;
  logic [CW-1:0]   w_cnt_inc;
  logic            w_last;
  logic            w_match;

  assign w_fb        = r_lfsr[15] ^ bus.s_in;
  assign w_lfsr_next = {r_lfsr[14] ^ w_fb, r_lfsr[13:2], r_lfsr[1] ^ w_fb, r_lfsr[0], w_fb};
  assign w_cnt_inc   = r_cnt + CW'(1);
  assign w_last      = (w_cnt_inc == CW'(TOTAL));
  // Result is judged on the post-shift value so it registers on the final bit's edge.
  assign w_match     = (w_lfsr_next == RESIDUAL);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_lfsr    <= PRESET;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ok      <= 1'b0;
      r_err     <= 1'b0;
      r_len_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.crc_start) begin
            r_lfsr  <= PRESET;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RECV;
          end
        end
        S_RECV: begin
          // Abort outranks the final bit and a restart; restart outranks a bit.
          if (bus.pkt_abort) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_ok      <= 1'b0;
            r_err     <= 1'b1;
            r_len_err <= 1'b1;
            r_state   <= S_DONE;
          end else if (bus.crc_start) begin
            r_lfsr <= PRESET;
            r_cnt  <= '0;
          end else if (bus.bit_en) begin
            r_lfsr <= w_lfsr_next;
            r_cnt  <= w_cnt_inc;
            if (w_last) begin
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_ok      <= w_match;
              r_err     <= ~w_match;
              r_len_err <= 1'b0;
              r_state   <= S_DONE;
            end
          end
        end
        S_DONE: begin
          // A crc_start alongside the ack is deliberately dropped.
          if (bus.crc_rec) begin
            r_done    <= 1'b0;
            r_ok      <= 1'b0;
            r_err     <= 1'b0;
            r_len_err <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.crc_busy = r_busy;
  assign bus.crc_done = r_done;
  assign bus.crc_ok   = r_ok;
  assign bus.crc_err  = r_err;
  assign bus.len_err  = r_len_err;
  assign bus.crc_rem  = r_lfsr;

endmodule

// File: tb/tb_crc16_check.sv
// tb_crc16_check
// Directed bench for crc16_check (DATA_BITS=64). Stimulus pushes the expected
// result of each packet into a queue; a monitor pops and compares whenever
// crc_done rises.
module tb_crc16_check;

  logic clk;
  logic rst_n;
  crc16_check_if bus();

  crc16_check #(.DATA_BITS(64)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ok;
    logic        len;
    logic [15:0] rem;
    int          mode;   // 0: rem exact, 1: rem must differ from 800D, 2: rem not checked
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic seen_done = 1'b0;

  localparam logic [63:0] PAYLOAD = 64'h0123_4567_89AB_CDEF;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Transmit-side reference: shift-left CRC16 with poly 8005, preset FFFF, sent complemented.
  function automatic logic [15:0] tx_step(input logic [15:0] r, input logic b);
    logic fb;
    fb = r[15] ^ b;
    return {r[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
  endfunction

  function automatic logic [79:0] make_stream(input logic [63:0] p);
    logic [15:0] r;
    r = 16'hFFFF;
    for (int i = 63; i >= 0; i--) r = tx_step(r, p[i]);
    return {p, ~r};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_res(input logic ok, input logic len, input logic [15:0] rem, input int mode);
    exp_t e;
    e.ok = ok; e.len = len; e.rem = rem; e.mode = mode;
    exp_q.push_back(e);
  endtask

  task automatic start_pkt();
    bus.crc_start = 1'b1;
    cyc();
    bus.crc_start = 1'b0;
  endtask

  // Sends bits first..first+n-1 of the stream (index 0 = first bit on the wire).
  task automatic send_bits(input logic [79:0] st, input int first, input int n, input bit gaps);
    logic [15:0] prev;
    for (int k = first; k < first + n; k++) begin
      if (gaps) begin
        while ($urandom_range(1) == 0) begin
          bus.bit_en = 1'b0;
          prev = bus.crc_rem;
          cyc();
          chk("gap_hold", bus.crc_rem, prev);
        end
      end
      bus.bit_en = 1'b1;
      bus.s_in   = st[79-k];
      cyc();
    end
    bus.bit_en = 1'b0;
    bus.s_in   = 1'b0;
  endtask

  task automatic ack();
    bus.crc_rec = 1'b1;
    cyc();
    bus.crc_rec = 1'b0;
    chk("ack_done_clr", {15'd0, bus.crc_done}, 16'd0);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst_n || !bus.crc_done) begin
      seen_done = 1'b0;
    end else if (!seen_done) begin
      exp_t e;
      seen_done = 1'b1;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: got done=1 expected no result pending at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("crc_ok",  {15'd0, bus.crc_ok},  {15'd0, e.ok});
        chk("crc_err", {15'd0, bus.crc_err}, {15'd0, ~e.ok});
        chk("len_err", {15'd0, bus.len_err}, {15'd0, e.len});
        if (e.mode == 0) chk("crc_rem", bus.crc_rem, e.rem);
        else if (e.mode == 1) chk("crc_rem_bad", {15'd0, bus.crc_rem != 16'h800D}, 16'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    logic [79:0] good;
    logic [79:0] bad;
    good = make_stream(PAYLOAD);
    bad  = good ^ (80'd1 << (79 - 17));

    bus.crc_start = 1'b0; bus.s_in = 1'b0; bus.bit_en = 1'b0;
    bus.pkt_abort = 1'b0; bus.crc_rec = 1'b0;
    rst_n = 1'b0;
    #23;
    chk("rst_busy", {15'd0, bus.crc_busy}, 16'd0);
    chk("rst_done", {15'd0, bus.crc_done}, 16'd0);
    chk("rst_ok",   {15'd0, bus.crc_ok},   16'd0);
    chk("rst_err",  {15'd0, bus.crc_err},  16'd0);
    chk("rst_len",  {15'd0, bus.len_err},  16'd0);
    chk("rst_rem",  bus.crc_rem, 16'hFFFF);
    rst_n = 1'b1;
    cyc();

    // Good packet, continuous.
    expect_res(1'b1, 1'b0, 16'h800D, 0);
    start_pkt();
    chk("start_busy", {15'd0, bus.crc_busy}, 16'd1);
    send_bits(good, 0, 80, 1'b0);
    chk("good_done_lat", {15'd0, bus.crc_done}, 16'd1);
    chk("good_busy_off", {15'd0, bus.crc_busy}, 16'd0);
    cyc();
    ack();

    // Corrupted payload bit 17.
    expect_res(1'b0, 1'b0, 16'h0000, 1);
    start_pkt();
    send_bits(bad, 0, 80, 1'b0);
    chk("bad_done_lat", {15'd0, bus.crc_done}, 16'd1);
    cyc();
    ack();

    // Gapped good packet.
    expect_res(1'b1, 1'b0, 16'h800D, 0);
    start_pkt();
    send_bits(good, 0, 80, 1'b1);
    chk("gap_done_lat", {15'd0, bus.crc_done}, 16'd1);
    cyc();
    ack();

    // Abort after 10 bits; 10-bit LFSR value of 0000_0001_00 is 7419.
    expect_res(1'b0, 1'b1, 16'h7419, 0);
    start_pkt();
    send_bits(good, 0, 10, 1'b0);
    bus.pkt_abort = 1'b1; bus.bit_en = 1'b1; bus.s_in = good[79-10];
    cyc();
    bus.pkt_abort = 1'b0; bus.bit_en = 1'b0;
    chk("abort_done_lat", {15'd0, bus.crc_done}, 16'd1);
    chk("abort_frozen", bus.crc_rem, 16'h7419);
    // DONE ignores bits.
    bus.bit_en = 1'b1; bus.s_in = 1'b1;
    cyc();
    bus.bit_en = 1'b0;
    chk("done_ignores_bit", bus.crc_rem, 16'h7419);
    ack();

    // Abort coincident with the final bit.
    expect_res(1'b0, 1'b1, 16'h0000, 2);
    start_pkt();
    send_bits(good, 0, 79, 1'b0);
    bus.pkt_abort = 1'b1; bus.bit_en = 1'b1; bus.s_in = good[0];
    cyc();
    bus.pkt_abort = 1'b0; bus.bit_en = 1'b0;
    chk("abort_last_done", {15'd0, bus.crc_done}, 16'd1);
    cyc();
    ack();

    // Restart after 30 bits (start asserted together with bit_en), then a full packet.
    expect_res(1'b1, 1'b0, 16'h800D, 0);
    start_pkt();
    send_bits(bad, 0, 30, 1'b0);
    bus.crc_start = 1'b1; bus.bit_en = 1'b1; bus.s_in = 1'b1;
    cyc();
    bus.crc_start = 1'b0; bus.bit_en = 1'b0;
    chk("restart_preset", bus.crc_rem, 16'hFFFF);
    chk("restart_busy", {15'd0, bus.crc_busy}, 16'd1);
    send_bits(good, 0, 80, 1'b0);
    chk("restart_done_lat", {15'd0, bus.crc_done}, 16'd1);
    cyc();
    // Ack together with start: start dropped.
    bus.crc_rec = 1'b1; bus.crc_start = 1'b1;
    cyc();
    bus.crc_rec = 1'b0; bus.crc_start = 1'b0;
    chk("rec_start_done", {15'd0, bus.crc_done}, 16'd0);
    chk("rec_start_busy", {15'd0, bus.crc_busy}, 16'd0);
    cyc();
    chk("rec_start_busy2", {15'd0, bus.crc_busy}, 16'd0);

    // Reset after 40 bits.
    start_pkt();
    send_bits(good, 0, 40, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {15'd0, bus.crc_busy}, 16'd0);
    chk("mid_rst_done", {15'd0, bus.crc_done}, 16'd0);
    chk("mid_rst_rem",  bus.crc_rem, 16'hFFFF);
    cyc();
    rst_n = 1'b1;
    cyc();
    expect_res(1'b1, 1'b0, 16'h800D, 0);
    start_pkt();
    send_bits(good, 0, 80, 1'b0);
    chk("post_rst_done", {15'd0, bus.crc_done}, 16'd1);
    cyc();
    ack();

    cyc();
    cyc();
    chk("queue_empty", 16'(exp_q.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
